// File: rtl/lsu_mem_port_pkg.sv
// -----------------------------------------------------------------------------
// lsu_mem_port_pkg
// Shared load/store definitions for the LSU memory port: funct3 encodings for
// loads and stores, the FSM state type, the latched-request record and the
// op-legality helper.
// -----------------------------------------------------------------------------
package lsu_mem_port_pkg;

  // Load funct3 encodings
  localparam logic [2:0] LSU_LB  = 3'd0;
  localparam logic [2:0] LSU_LH  = 3'd1;
  localparam logic [2:0] LSU_LW  = 3'd2;
  localparam logic [2:0] LSU_LBU = 3'd4;
  localparam logic [2:0] LSU_LHU = 3'd5;

  // Store funct3 encodings
  localparam logic [2:0] LSU_SB  = 3'd0;
  localparam logic [2:0] LSU_SH  = 3'd1;
  localparam logic [2:0] LSU_SW  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  // Request fields kept for the duration of one access.
  typedef struct packed {
    logic        store;
    logic [2:0]  op;
    logic [1:0]  offset;
    logic [31:0] wdata;
  } lsu_req_t;

  // Legal funct3 values differ between loads and stores.
  function automatic logic lsu_op_valid(input logic store, input logic [2:0] op);
    if (store) return op inside {LSU_SB, LSU_SH, LSU_SW};
    return op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_port_if
// Bundles the core request/response channel and the data-RAM channel of the
// LSU memory port.
//   slave  : the LSU view (takes core requests, drives the RAM)
//   master : the environment view (core plus RAM)
// Parameter ADDR_W sets the RAM word-address width.
// -----------------------------------------------------------------------------
interface lsu_mem_port_if #(
  parameter int ADDR_W = 7
);

  // Core request
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;

  // Core response
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  // Data RAM
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport slave (
    input  req_valid, req_store, req_op, req_addr, req_wdata,
    input  mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_op, req_addr, req_wdata,
    output mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_mem_port_align.sv
// -----------------------------------------------------------------------------
// lsu_mem_port_align
// Combinational byte-lane logic for one access.
//   op        : funct3 (size in op[1:0], unsigned-load flag in op[2])
//   offset    : byte offset within the word (addr[1:0])
//   wdata     : raw store data
//   rdata     : word read from the RAM
//   be        : byte-lane enables
//   wdata_rep : store data replicated across all lanes of its size
//   rdata_ext : selected load bytes, aligned and sign/zero extended
//   misalign  : half-word or word access not on its natural boundary
// -----------------------------------------------------------------------------
module lsu_mem_port_align (
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rdata[{offset, 3'b000} +: 8];
  assign rd_half = offset[1] ? rdata[31:16] : rdata[15:0];

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = rdata;
    misalign  = 1'b0;
    case (op[1:0])
      2'd0: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = op[2] ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      end
      2'd1: begin
        be        = 4'b0011 << offset;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = op[2] ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
        misalign  = offset[0];
      end
      2'd2: begin
        be       = 4'b1111;
        misalign = |offset;
      end
      default: ;  // op[1:0]==3 is rejected as an invalid op upstream
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// -----------------------------------------------------------------------------
// lsu_mem_port
// Load/store unit between the core MEMORY stage and a word-addressed data RAM.
// Accepts one request in IDLE, rejects invalid or misaligned accesses without
// touching the RAM, otherwise holds a RAM request until mem_ack (or timeout),
// then returns a single-cycle response.
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : lsu_mem_port_if.slave (core request/response and RAM channel)
// Parameters:
//   ADDR_W  : RAM word-address width, mem_addr = req_addr[ADDR_W+1:2]
//   TIMEOUT : max REQ cycles waiting for mem_ack, 0 disables the timeout
// -----------------------------------------------------------------------------
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  lsu_mem_port_if.slave       bus
);

  localparam int               TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_t        state, state_nxt;
  lsu_req_t          req_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [TMO_W-1:0]  tmo_q;

  logic              in_idle;
  logic [2:0]        al_op;
  logic [1:0]        al_off;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_rdata;
  logic              al_misalign;
  logic              req_bad;
  logic              tmo_hit;

  assign in_idle = (state == ST_IDLE);

  // One aligner serves both phases: in IDLE it judges the incoming request,
  // afterwards it works on the latched request.
  assign al_op  = in_idle ? bus.req_op        : req_q.op;
  assign al_off = in_idle ? bus.req_addr[1:0] : req_q.offset;

  lsu_mem_port_align u_align (
    .op        (al_op),
    .offset    (al_off),
    .wdata     (req_q.wdata),
    .rdata     (bus.mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata),
    .misalign  (al_misalign)
  );

  assign req_bad = !lsu_op_valid(bus.req_store, bus.req_op) || al_misalign;
  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_be     = 4'b0000;
    bus.mem_addr   = '0;
    bus.mem_wdata  = 32'h0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = req_bad ? ST_RESP : ST_REQ;
      end
      ST_REQ: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = req_q.store;
        bus.mem_be    = al_be;
        bus.mem_addr  = waddr_q;
        bus.mem_wdata = al_wdata;
        // An ack on the last allowed cycle still completes the access.
        if (bus.mem_ack || tmo_hit) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        state_nxt      = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // resp_rdata holds the last response value between responses.
  assign bus.resp_rdata = rdata_q;

  // ---------------------------------------------------------------------------
  // Request latch, response data and timeout counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_q   <= '0;
      waddr_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      tmo_q   <= '0;
    end else begin
      // Counts REQ cycles; cleared whenever the FSM is elsewhere.
      tmo_q <= (state == ST_REQ) ? tmo_q + TMO_W'(1) : '0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            req_q   <= '{store:  bus.req_store,
                         op:     bus.req_op,
                         offset: bus.req_addr[1:0],
                         wdata:  bus.req_wdata};
            // Upper address bits wrap silently onto the RAM.
            waddr_q <= bus.req_addr[ADDR_W+1:2];
            err_q   <= req_bad;
            if (req_bad) rdata_q <= 32'h0;
          end
        end
        ST_REQ: begin
          if (bus.mem_ack) begin
            err_q   <= 1'b0;
            rdata_q <= req_q.store ? 32'h0 : al_rdata;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit between the core's MEMORY stage and the data RAM.
- Accepts one load or store per request handshake and checks alignment.
- Drives a word-addressed RAM with byte enables, waits a variable number of cycles for acknowledge, then returns one response pulse.
- Load responses are aligned and sign- or zero-extended.

Parameters:
- ADDR_W, 7, RAM word-address width; mem_addr = addr[ADDR_W+1:2].
- TIMEOUT, 16, maximum cycles in REQ waiting for mem_ack; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the clk edge).
- req_valid  in  1  core presents a request.
- req_ready  out  1  high only in IDLE.
- req_store  in  1  1=store, 0=load.
- req_op  in  3  funct3: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low bits are used for SB/SH.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access, invalid op, or timeout; valid with resp_valid.
- mem_req  out  1  RAM access request.
- mem_we  out  1  write enable.
- mem_be  out  4  byte-lane enables.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  lane-replicated write data.
- mem_rdata  in  32  read word; valid when mem_ack is high.
- mem_ack  in  1  RAM completes the access this cycle.

Behaviour:
- Reset (rst==0): state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_req=0; mem_we=0; mem_be=0; mem_addr=0; mem_wdata=0; timeout counter=0.
  - Reset applies in any state. An access in flight is abandoned, with no response and no mem_req in the next cycle.
- States: IDLE, REQ, RESP.
- IDLE:
  - On the edge where req_valid&&req_ready, latch store flag, op, addr and wdata.
  - Error condition, any of:
    - invalid op: loads 3/6/7, stores >2;
    - LH/LHU/SH with addr[0]=1;
    - LW/SW with addr[1:0]!=0.
  - On error: go to RESP with err=1 and no memory access. Otherwise go to REQ.
- REQ:
  - mem_req=1, and mem_we, mem_be, mem_addr, mem_wdata are held stable until mem_ack is sampled high.
  - On mem_ack: capture mem_rdata for loads, then go to RESP with err=0. mem_req is 0 in the next cycle.
  - The timeout counter increments each REQ cycle. If TIMEOUT!=0 and the count reaches TIMEOUT with no ack, go to RESP with err=1 and drop mem_req.
  - mem_ack is ignored outside REQ.
- RESP:
  - resp_valid=1 for exactly one cycle, carrying resp_rdata and resp_err.
  - Next state is IDLE.
  - resp_valid and resp_err return to 0 in the following cycle; resp_rdata holds its value.
- Byte lanes, with o=addr[1:0]:
  - SB/LB/LBU: mem_be=4'b0001<<o; wdata={4{wdata[7:0]}}.
  - SH/LH/LHU: mem_be=4'b0011<<o; wdata={2{wdata[15:0]}}.
  - SW/LW: mem_be=4'b1111.
  - mem_we=1 only for stores. Load mem_be is informational.
- Load extract: s=mem_rdata>>(8*o).
  - LB: sign-extend s[7:0]. LBU: zero-extend s[7:0].
  - LH: sign-extend s[15:0]. LHU: zero-extend s[15:0].
  - LW: mem_rdata unchanged.
- Latency:
  - Request accepted at edge N: mem_req is high in cycle N+1.
  - mem_ack sampled at edge M: resp_valid is high in cycle M+1.
  - Minimum with immediate ack: response 2 cycles after acceptance, and the next request accepted 3 cycles after the previous one.
  - Error without access: resp_valid in cycle N+1.
- Address width: mem_addr=addr[ADDR_W+1:2]. Higher address bits are ignored (wrap-around), not flagged.
- Back-to-back: req_valid held high is accepted again at the first IDLE cycle after RESP.

Decomposition:
- Shared rv32i header holds LSU_LB/LH/LW/LBU/LHU and LSU_SB/SH/SW defines, alongside the existing LSU_* constants.
- Sub-module lsu_align (combinational):
  - inputs: op, offset, store data, read word;
  - outputs: mem_be, replicated wdata, extended load data, misalign flag.
- lsu_mem_port holds the FSM, latches and timeout counter.

Test Plan:
1. SW addr=0x10, wdata=0xDEADBEEF, ack after 2 cycles -> mem_req for 2 cycles; mem_addr=4, mem_be=1111, mem_we=1; resp_valid 1 cycle after ack with resp_err=0.
2. LB addr=0x13, mem_rdata=0x80112233 with immediate ack -> mem_be=1000, resp_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
3. LH addr=0x21 -> resp_valid in the cycle after acceptance with resp_err=1, mem_req never asserted. SB addr=0x21, wdata=0xAB -> mem_be=0010, mem_wdata=0xABABABAB.
4. TIMEOUT=16, LW addr=0x8, mem_ack held low -> mem_req high exactly 16 cycles, then resp_valid with resp_err=1 and resp_rdata=0.
5. rst driven 0 in the 2nd REQ cycle -> next cycle mem_req=0 and req_ready=1; no resp_valid ever appears. A late mem_ack pulse is ignored.
6. req_valid held high for 3 loads (LHU 0x2 with rdata=0xBEEF0000, LW 0x4, LB 0x7) with immediate ack -> responses 0x0000BEEF, the word, and sign-extended byte 3; each accepted 3 cycles apart.
